// File: rtl/uart_prog_pkg.sv
// Shared opcodes, response codes and FSM state encoding for the UART program controller.
// UART_PROG_CHECKSUM_EN adds the GET_CSUM state for the 4-byte checksummed write.
package uart_prog_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_GO    = 8'h47;
  localparam logic [7:0] OP_HALT  = 8'h48;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
`ifdef UART_PROG_CHECKSUM_EN
    GET_CSUM,
`endif
    WRITE,
    READ_WAIT,
    SEND,
    WAIT_TX
  } state_t;

endpackage

// File: rtl/uart_prog_timeout.sv
// Inter-byte timeout: reloads on every received byte, counts down while a command is
// partially received, and strobes expired when the budget of TIMEOUT_CLKS cycles is used up.
module uart_prog_timeout #(
  parameter int TIMEOUT_CLKS = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic load,
  output logic expired
);

  localparam int W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT_CLKS - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (run && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  // A byte arriving on the expiry cycle wins; the command continues.
  assign expired = run && !load && (cnt == '0);

endmodule

// File: rtl/uart_prog_ctrl.sv
// Byte-stream command sequencer: host bytes become RAM writes/reads and CPU halt/run,
// with one status byte returned per command. UART_PROG_CHECKSUM_EN adds a checksum byte to W.
module uart_prog_ctrl
  import uart_prog_pkg::*;
#(
  parameter int TIMEOUT_CLKS = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_dv,
  input  logic [7:0] rx_byte,
  input  logic       tx_active,
  input  logic       tx_done,
  output logic       tx_dv,
  output logic [7:0] tx_byte,
  output logic [3:0] mem_addr,
  output logic [7:0] mem_data,
  output logic       mem_we,
  input  logic [7:0] mem_rdata,
  output logic       cpu_halt,
  output logic [3:0] led
);

  state_t     state;
  logic       is_write;
  logic       rd_settled;
  logic [2:0] led_flags;  // {overrun seen, timeout seen, last NAK}
  logic       tmo_run;
  logic       tmo_expired;

  always_comb begin
    tmo_run = (state == GET_ADDR) || (state == GET_DATA);
`ifdef UART_PROG_CHECKSUM_EN
    if (state == GET_CSUM) tmo_run = 1'b1;
`endif
  end

  uart_prog_timeout #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timeout (
    .clk     (clk),
    .rst     (reset),
    .run     (tmo_run),
    .load    (rx_dv),
    .expired (tmo_expired)
  );

  assign led = {led_flags, (state != IDLE)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      is_write   <= 1'b0;
      rd_settled <= 1'b0;
      led_flags  <= '0;
      tx_dv      <= 1'b0;
      tx_byte    <= '0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_we     <= 1'b0;
      cpu_halt   <= 1'b1;
    end else begin
      tx_dv  <= 1'b0;
      mem_we <= 1'b0;

      if (rx_dv && (state == WRITE || state == READ_WAIT ||
                    state == SEND  || state == WAIT_TX)) begin
        led_flags[2] <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (rx_dv) begin
            case (rx_byte)
              OP_WRITE: begin is_write <= 1'b1; state <= GET_ADDR; end
              OP_READ:  begin is_write <= 1'b0; state <= GET_ADDR; end
              OP_GO: begin
                cpu_halt <= 1'b0; tx_byte <= ACK; led_flags[0] <= 1'b0; state <= SEND;
              end
              OP_HALT: begin
                cpu_halt <= 1'b1; tx_byte <= ACK; led_flags[0] <= 1'b0; state <= SEND;
              end
              default: begin
                tx_byte <= NAK; led_flags[0] <= 1'b1; state <= SEND;
              end
            endcase
          end
        end

        GET_ADDR: begin
          if (rx_dv) begin
            if (rx_byte[7:4] != 4'h0) begin
              tx_byte <= NAK; led_flags[0] <= 1'b1; state <= SEND;
            end else begin
              mem_addr   <= rx_byte[3:0];
              rd_settled <= 1'b0;
              state      <= is_write ? GET_DATA : READ_WAIT;
            end
          end else if (tmo_expired) begin
            led_flags[1] <= 1'b1; state <= IDLE;
          end
        end

        GET_DATA: begin
          if (rx_dv) begin
            mem_data <= rx_byte;
`ifdef UART_PROG_CHECKSUM_EN
            state <= GET_CSUM;
`else
            mem_we <= 1'b1;
            state  <= WRITE;
`endif
          end else if (tmo_expired) begin
            led_flags[1] <= 1'b1; state <= IDLE;
          end
        end

`ifdef UART_PROG_CHECKSUM_EN
        GET_CSUM: begin
          if (rx_dv) begin
            if (rx_byte == ({4'h0, mem_addr} ^ mem_data)) begin
              mem_we <= 1'b1; state <= WRITE;
            end else begin
              tx_byte <= NAK; led_flags[0] <= 1'b1; state <= SEND;
            end
          end else if (tmo_expired) begin
            led_flags[1] <= 1'b1; state <= IDLE;
          end
        end
`endif

        WRITE: begin
          tx_byte <= ACK; led_flags[0] <= 1'b0; state <= SEND;
        end

        // The RAM output follows the new address one cycle late, so sample on the second cycle.
        READ_WAIT: begin
          if (rd_settled) begin
            tx_byte <= mem_rdata; state <= SEND;
          end else begin
            rd_settled <= 1'b1;
          end
        end

        SEND: begin
          if (!tx_active) begin
            tx_dv <= 1'b1; state <= WAIT_TX;
          end
        end

        WAIT_TX: begin
          if (tx_done) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_prog_ctrl.sv
// Directed bench for uart_prog_ctrl: command table plus timeout, overrun and checksum sequences.
module tb_uart_prog_ctrl;

  localparam int TCLKS = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       tx_busy;
  logic       tx_hold;
  logic       tx_active;
  logic       tx_done;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic       cpu_halt;
  logic [3:0] led;

  logic [7:0] ram [16];

  int n_cmp = 0;
  int n_err = 0;
  int we_cnt = 0;
  int tx_cnt = 0;
  logic [3:0] we_addr = '0;
  logic [7:0] we_data = '0;
  logic [7:0] tx_last = '0;

  assign tx_active = tx_busy | tx_hold;

  always #5 clk = ~clk;

  uart_prog_ctrl #(.TIMEOUT_CLKS(TCLKS)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_dv     (rx_dv),
    .rx_byte   (rx_byte),
    .tx_active (tx_active),
    .tx_done   (tx_done),
    .tx_dv     (tx_dv),
    .tx_byte   (tx_byte),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .cpu_halt  (cpu_halt),
    .led       (led)
  );

  // Synchronous-read RAM, preloaded with 3C at address 9 during reset.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) ram[i] <= (i == 9) ? 8'h3C : 8'h00;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_data;
    end
    mem_rdata <= ram[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt  = we_cnt + 1;
      we_addr = mem_addr;
      we_data = mem_data;
    end
    if (tx_dv) begin
      tx_cnt  = tx_cnt + 1;
      tx_last = tx_byte;
    end
  end

  // Transmitter model: busy for a few cycles after each tx_dv, then a tx_done strobe.
  initial begin
    tx_busy = 1'b0;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_dv) begin
        tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        tx_done = 1'b1;
        tx_busy = 1'b0;
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_dv   = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1;
    rx_dv   = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (led[0] && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({name, " back to idle"}, {31'b0, led[0]}, 32'h0);
  endtask

  typedef struct {
    logic [3:0][7:0] b;
    int         n;
    logic [7:0] exp_tx;
    int         exp_we;
    logic [3:0] exp_addr;
    logic [7:0] exp_data;
    logic       exp_halt;
    logic [3:0] exp_led;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input int n, input logic [7:0] etx, input int ewe,
                              input logic [3:0] ea, input logic [7:0] ed,
                              input logic eh, input logic [3:0] el);
    vec_t v;
    v.b = {8'h00, b2, b1, b0};
    v.n = n;
`ifdef UART_PROG_CHECKSUM_EN
    if (b0 == 8'h57 && n == 3) begin
      v.b[3] = b1 ^ b2;
      v.n    = 4;
    end
`endif
    v.exp_tx = etx; v.exp_we = ewe; v.exp_addr = ea; v.exp_data = ed;
    v.exp_halt = eh; v.exp_led = el;
    return v;
  endfunction

  vec_t vecs [14];

  initial begin
    int we0;
    int tx0;
    string nm;

    reset   = 1'b1;
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
    tx_hold = 1'b0;

    vecs[0]  = mk(8'h57, 8'h03, 8'hA5, 3, 8'h06, 1, 4'h3, 8'hA5, 1'b1, 4'b0000);
    vecs[1]  = mk(8'h52, 8'h09, 8'h00, 2, 8'h3C, 0, 4'h9, 8'hA5, 1'b1, 4'b0000);
    vecs[2]  = mk(8'h47, 8'h00, 8'h00, 1, 8'h06, 0, 4'h9, 8'hA5, 1'b0, 4'b0000);
    vecs[3]  = mk(8'h48, 8'h00, 8'h00, 1, 8'h06, 0, 4'h9, 8'hA5, 1'b1, 4'b0000);
    vecs[4]  = mk(8'h57, 8'h1F, 8'h00, 2, 8'h15, 0, 4'h9, 8'hA5, 1'b1, 4'b0010);
    vecs[5]  = mk(8'h57, 8'h00, 8'h11, 3, 8'h06, 1, 4'h0, 8'h11, 1'b1, 4'b0000);
    vecs[6]  = mk(8'h52, 8'h03, 8'h00, 2, 8'hA5, 0, 4'h3, 8'h11, 1'b1, 4'b0000);
    vecs[7]  = mk(8'h99, 8'h00, 8'h00, 1, 8'h15, 0, 4'h3, 8'h11, 1'b1, 4'b0010);
    vecs[8]  = mk(8'h47, 8'h00, 8'h00, 1, 8'h06, 0, 4'h3, 8'h11, 1'b0, 4'b0000);
    vecs[9]  = mk(8'h52, 8'h00, 8'h00, 2, 8'h11, 0, 4'h0, 8'h11, 1'b0, 4'b0000);
    vecs[10] = mk(8'h57, 8'h0F, 8'hFF, 3, 8'h06, 1, 4'hF, 8'hFF, 1'b0, 4'b0000);
    vecs[11] = mk(8'h52, 8'h0F, 8'h00, 2, 8'hFF, 0, 4'hF, 8'hFF, 1'b0, 4'b0000);
    vecs[12] = mk(8'h52, 8'h10, 8'h00, 2, 8'h15, 0, 4'hF, 8'hFF, 1'b0, 4'b0010);
    vecs[13] = mk(8'h48, 8'h00, 8'h00, 1, 8'h06, 0, 4'hF, 8'hFF, 1'b1, 4'b0000);

    repeat (3) @(negedge clk);
    check("reset tx_dv",    {31'b0, tx_dv},    32'h0);
    check("reset tx_byte",  {24'b0, tx_byte},  32'h0);
    check("reset mem_addr", {28'b0, mem_addr}, 32'h0);
    check("reset mem_data", {24'b0, mem_data}, 32'h0);
    check("reset mem_we",   {31'b0, mem_we},   32'h0);
    check("reset cpu_halt", {31'b0, cpu_halt}, 32'h1);
    check("reset led",      {28'b0, led},      32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      we0 = we_cnt;
      tx0 = tx_cnt;
      for (int j = 0; j < vecs[i].n; j++) send_byte(vecs[i].b[j]);
      nm = $sformatf("v%0d", i);
      wait_idle(nm, 200);
      check({nm, " tx count"}, tx_cnt - tx0, 32'd1);
      check({nm, " tx byte"}, {24'b0, tx_last}, {24'b0, vecs[i].exp_tx});
      check({nm, " we count"}, we_cnt - we0, vecs[i].exp_we);
      if (vecs[i].exp_we != 0) begin
        check({nm, " we addr"}, {28'b0, we_addr}, {28'b0, vecs[i].exp_addr});
        check({nm, " we data"}, {24'b0, we_data}, {24'b0, vecs[i].exp_data});
      end
      check({nm, " mem_addr"}, {28'b0, mem_addr}, {28'b0, vecs[i].exp_addr});
      check({nm, " mem_data"}, {24'b0, mem_data}, {24'b0, vecs[i].exp_data});
      check({nm, " cpu_halt"}, {31'b0, cpu_halt}, {31'b0, vecs[i].exp_halt});
      check({nm, " led"}, {28'b0, led}, {28'b0, vecs[i].exp_led});
    end

    // Timeout: partial write, then silence for the whole budget.
    we0 = we_cnt;
    tx0 = tx_cnt;
    send_byte(8'h57);
    send_byte(8'h04);
    repeat (95) @(negedge clk);
    check("tmo still busy", {31'b0, led[0]}, 32'h1);
    check("tmo not yet flagged", {31'b0, led[2]}, 32'h0);
    repeat (10) @(negedge clk);
    check("tmo idle", {31'b0, led[0]}, 32'h0);
    check("tmo flagged", {31'b0, led[2]}, 32'h1);
    check("tmo no write", we_cnt - we0, 32'd0);
    check("tmo no response", tx_cnt - tx0, 32'd0);
    send_byte(8'h48);
    wait_idle("tmo halt", 200);
    check("tmo halt tx count", tx_cnt - tx0, 32'd1);
    check("tmo halt ack", {24'b0, tx_last}, 32'h06);
    check("tmo halt led", {28'b0, led}, 32'b0100);

    // Gaps just under the budget must not abort the command.
    we0 = we_cnt;
    send_byte(8'h57);
    repeat (90) @(negedge clk);
    send_byte(8'h06);
    repeat (90) @(negedge clk);
    send_byte(8'h77);
`ifdef UART_PROG_CHECKSUM_EN
    repeat (90) @(negedge clk);
    send_byte(8'h71);
`endif
    wait_idle("gap write", 200);
    check("gap write count", we_cnt - we0, 32'd1);
    check("gap write addr", {28'b0, we_addr}, 32'h6);
    check("gap write data", {24'b0, we_data}, 32'h77);
    check("gap write ack", {24'b0, tx_last}, 32'h06);

    // Overrun: transmitter stays busy, a G arrives while the H response waits.
    tx_hold = 1'b1;
    tx0 = tx_cnt;
    send_byte(8'h48);
    repeat (10) @(negedge clk);
    send_byte(8'h47);
    repeat (500) @(negedge clk);
    check("ovr held no tx", tx_cnt - tx0, 32'd0);
    check("ovr flagged", {31'b0, led[3]}, 32'h1);
    check("ovr still busy", {31'b0, led[0]}, 32'h1);
    check("ovr halt kept", {31'b0, cpu_halt}, 32'h1);
    tx_hold = 1'b0;
    wait_idle("ovr", 200);
    check("ovr tx count", tx_cnt - tx0, 32'd1);
    check("ovr ack", {24'b0, tx_last}, 32'h06);
    check("ovr halt after", {31'b0, cpu_halt}, 32'h1);
    check("ovr led", {28'b0, led}, 32'b1100);

`ifdef UART_PROG_CHECKSUM_EN
    we0 = we_cnt;
    send_byte(8'h57); send_byte(8'h02); send_byte(8'hF0); send_byte(8'hF1);
    wait_idle("csum bad", 200);
    check("csum bad nak", {24'b0, tx_last}, 32'h15);
    check("csum bad no write", we_cnt - we0, 32'd0);
    check("csum bad led1", {31'b0, led[1]}, 32'h1);
    send_byte(8'h57); send_byte(8'h02); send_byte(8'hF0); send_byte(8'hF2);
    wait_idle("csum good", 200);
    check("csum good ack", {24'b0, tx_last}, 32'h06);
    check("csum good write", we_cnt - we0, 32'd1);
    check("csum good addr", {28'b0, we_addr}, 32'h2);
    check("csum good data", {24'b0, we_data}, 32'hF0);
    check("csum good led1", {31'b0, led[1]}, 32'h0);
    send_byte(8'h52); send_byte(8'h02);
    wait_idle("csum readback", 200);
    check("csum readback data", {24'b0, tx_last}, 32'hF0);
`endif

    // Reset is asynchronous: takes effect between clock edges.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async reset led", {28'b0, led}, 32'h0);
    check("async reset halt", {31'b0, cpu_halt}, 32'h1);
    check("async reset addr", {28'b0, mem_addr}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_prog_ctrl.md
Name: uart_prog_ctrl

Overview:
Command sequencer between the UART receiver/transmitter and the 8-bit computer's 16x8 RAM program port. Parses a byte-stream protocol from the host into RAM writes, RAM reads and CPU halt/run control, and returns one status byte per command through the UART transmitter. Sits in the UART I/O top level, in place of the direct byte-to-address decode. It owns the RAM write enable and the CPU halt line.

Parameters:
TIMEOUT_CLKS, 50_000_000, maximum clk cycles between bytes of one command before the command is aborted (1 s at 50 MHz).

Ports:
clk  in  1  system clock (CLOCK_50 domain)
reset  in  1  asynchronous, active-high reset
rx_dv  in  1  one-cycle strobe from UART receiver: rx_byte valid
rx_byte  in  8  received byte
tx_active  in  1  UART transmitter busy
tx_done  in  1  one-cycle strobe: transmitter finished byte
tx_dv  out  1  one-cycle strobe to transmitter: send tx_byte
tx_byte  out  8  byte to transmit
mem_addr  out  4  RAM address
mem_data  out  8  RAM write data
mem_we  out  1  RAM write enable, one-cycle pulse
mem_rdata  in  8  RAM read data, valid 1 cycle after mem_addr is stable
cpu_halt  out  1  1 = CPU held stopped
led  out  4  status: [0] busy, [1] last NAK, [2] timeout seen, [3] overrun seen

Behaviour:
- Reset (async, active-high): state IDLE; tx_dv=0, tx_byte=0, mem_addr=0, mem_data=0, mem_we=0, cpu_halt=1, led=0, timeout counter=0.
- Opcodes: 0x57 'W' addr data; 0x52 'R' addr; 0x47 'G' (cpu_halt<=0); 0x48 'H' (cpu_halt<=1). Response bytes: ACK=0x06, NAK=0x15; 'R' returns the data byte instead of ACK.
- States: IDLE, GET_ADDR, GET_DATA, [GET_CSUM], WRITE, READ_WAIT, SEND, WAIT_TX.
- IDLE: on rx_dv: W/R -> GET_ADDR; G/H -> apply halt change, tx_byte<=ACK, go to SEND; any other byte -> tx_byte<=NAK, led[1]<=1, go to SEND.
- GET_ADDR: if rx_byte[7:4] != 0 -> NAK, go to SEND. Otherwise latch mem_addr. For W -> GET_DATA. For R -> READ_WAIT.
- GET_DATA: latch mem_data -> WRITE (or GET_CSUM when the optional feature is compiled in).
- WRITE: mem_we=1 for exactly one cycle, tx_byte<=ACK, go to SEND. Writes are allowed regardless of cpu_halt.
- READ_WAIT: one cycle; then tx_byte<=mem_rdata, go to SEND.
- SEND: wait while tx_active=1; when tx_active=0, pulse tx_dv for one cycle, go to WAIT_TX.
- WAIT_TX: on tx_done -> IDLE.
- led[1] is set by a NAK and cleared by the next ACK. led[0]=1 whenever state != IDLE.
- Timeout: the counter runs in GET_ADDR, GET_DATA and GET_CSUM and clears on every rx_dv. When it reaches TIMEOUT_CLKS-1, the command is dropped with no response and no write: led[2]<=1 (sticky until reset), go to IDLE.
- Overrun: rx_dv in SEND, WAIT_TX, WRITE or READ_WAIT: the byte is discarded and led[3]<=1 (sticky until reset).
- rx_dv on the same cycle the FSM returns to IDLE: the byte is discarded (counts as overrun).
- mem_addr and mem_data hold their last values between commands.
- Counter width: $clog2(TIMEOUT_CLKS).

Optional Feature:
UART_PROG_CHECKSUM_EN
- Defined: a W command carries a 4th byte equal to addr XOR data. GET_CSUM compares it; on mismatch there is no write, the response is NAK and led[1]<=1. R, G and H are unchanged.
- Undefined: GET_CSUM does not exist, and W is 3 bytes.

Decomposition:
- Package uart_prog_pkg: opcode constants (OP_WRITE, OP_READ, OP_GO, OP_HALT), ACK/NAK constants, and the state enum typedef.
- One sub-module, uart_prog_timeout: loadable down-counter with clear and expiry strobe, parameterised by TIMEOUT_CLKS.
- The FSM and output registers stay in uart_prog_ctrl.

Test Plan:
- Reset, then bytes 57 03 A5 -> one mem_we pulse with mem_addr=3, mem_data=A5; tx_byte=06; cpu_halt stays 1.
- RAM model holds 3C at addr 9; send 52 09 -> tx_dv once with tx_byte=3C; mem_we never asserted.
- Send 47, then 48 -> cpu_halt falls after the first byte and rises after the second; two ACKs (06).
- Send 57 1F -> NAK 15, no write, led[1]=1. Then 57 00 11 -> ACK, led[1]=0.
- TIMEOUT_CLKS=100; send 57 04, then idle for 100 cycles -> no write, no tx_dv, led[2]=1; a following 48 is ACKed.
- Hold tx_active=1 for 500 cycles after 48; inject rx_dv with 47 during SEND -> 47 discarded, led[3]=1, single ACK once tx_active falls, cpu_halt remains 1.
- With UART_PROG_CHECKSUM_EN: send 57 02 F0 F1 -> NAK, no write. Then 57 02 F0 F2 -> write of F0 to addr 2, ACK.
